// File: rtl/fft_sample_loader.sv
// fft_sample_loader: bit-reversed ping-pong frame buffer that emits stage-1 radix-2 DIT even/odd pairs
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   sample_in/valid/ready     : streaming signed sample input, ready = write bank not full
//   pair_out/valid/ready      : {odd, even} pair for the butterfly, held until handshake
//   pair_index, frame_start,
//   frame_last                : pair number within the frame and its first/last markers
//   overrun                   : sticky, a sample was offered while not ready
module fft_sample_loader #(
  parameter int input_size  = 16,
  parameter int num_samples = 8,
  localparam int aw = $clog2(num_samples),
  localparam int kw = (aw > 1) ? aw - 1 : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [input_size-1:0]   sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [2*input_size-1:0] pair_out,
  output logic                    pair_valid,
  input  logic                    pair_ready,
  output logic [kw-1:0]           pair_index,
  output logic                    frame_start,
  output logic                    frame_last,
  output logic                    overrun
);
  typedef enum logic [1:0] {IDLE, FETCH, SHOW} state_t;
  logic [input_size-1:0]   mem_q [2][num_samples];
  logic [1:0]              full_q, full_d;
  logic                    wbank_q, wbank_d, rbank_q, rbank_d;
  logic [aw-1:0]           w_q, w_d;
  logic [kw-1:0]           k_q, k_d;
  state_t                  st_q, st_d;
  logic [2*input_size-1:0] pair_q, pair_d;
  logic                    ovr_q, ovr_d;
  logic                    acc, last_k, done;
  logic [aw-1:0]           ev_a;

  function automatic logic [aw-1:0] bitrev(input logic [aw-1:0] a);
    for (int i = 0; i < aw; i++) bitrev[i] = a[aw-1-i];
  endfunction

  always_comb begin
    sample_ready = !full_q[wbank_q];
    acc          = sample_valid && sample_ready;
    last_k       = k_q == kw'(num_samples / 2 - 1);
    done         = st_q == SHOW && pair_ready && last_k;
    ev_a         = aw'({k_q, 1'b0});
    w_d          = acc ? w_q + 1'b1 : w_q;
    wbank_d      = wbank_q ^ (acc && &w_q);
    rbank_d      = rbank_q ^ done;
    ovr_d        = ovr_q | (sample_valid && !sample_ready);
    full_d       = full_q;
    if (acc && &w_q) full_d[wbank_q] = 1'b1;
    if (done) full_d[rbank_q] = 1'b0;
    st_d   = st_q;
    k_d    = k_q;
    pair_d = pair_q;
    case (st_q)
      IDLE: if (full_q[rbank_q]) begin
        k_d  = '0;
        st_d = FETCH;
      end
      FETCH: begin
        pair_d = {mem_q[rbank_q][ev_a | aw'(1)], mem_q[rbank_q][ev_a]};
        st_d   = SHOW;
      end
      SHOW: if (pair_ready) begin
        k_d  = last_k ? k_q : k_q + 1'b1;
        st_d = last_k ? IDLE : FETCH;
      end
      default: st_d = IDLE;
    endcase
    pair_valid  = st_q == SHOW;
    pair_out    = pair_q;
    pair_index  = k_q;
    frame_start = pair_valid && k_q == '0;
    frame_last  = pair_valid && last_k;
    overrun     = ovr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      w_q     <= '0;
      k_q     <= '0;
      st_q    <= IDLE;
      pair_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      w_q     <= w_d;
      k_q     <= k_d;
      st_q    <= st_d;
      pair_q  <= pair_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (acc) mem_q[wbank_q][bitrev(w_q)] <= sample_in;
  end
endmodule
